// File: rtl/plab4_net_router_output_terminal_ctrl_pkg.sv
// Shared definitions for the router terminal output ctrl and the input ctrls that
// raise reqs toward it: request/grant bit positions and a mod-3 index helper.
package plab4_net_router_output_terminal_ctrl_pkg;

  localparam int unsigned NUM_INPUTS = 3;

  typedef enum logic [1:0] {
    PREV = 2'd0,  // east-in neighbour
    TERM = 2'd1,  // local terminal
    NEXT = 2'd2   // west-in neighbour
  } port_idx_e;

  // Index of the input searched 'offset' places after 'base', wrapping modulo 3.
  function automatic logic [1:0] rr_index(input logic [1:0] base, input int unsigned offset);
    int unsigned sum;
    sum = int'(base) + offset;
    if (sum >= NUM_INPUTS) sum = sum - NUM_INPUTS;
    return 2'(sum);
  endfunction

endpackage

// File: rtl/plab4_net_RoundRobinArb3.sv
// Three-input round-robin arbiter; priority rotates to the input after the last winner.
module plab4_net_RoundRobinArb3
  import plab4_net_router_output_terminal_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] reqs,
  input  logic       en,
  output logic [2:0] grants,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] rr_q, rr_d;
  logic       found;
  logic [1:0] idx;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    idx    = 2'd0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      idx = rr_index(rr_q, i);
      if (!found && reqs[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    valid  = en && found;
    grants = valid ? (3'b001 << winner) : 3'b000;
    if (!valid) winner = 2'd0;
    rr_d = rr_q;
    if (valid) rr_d = rr_index(winner, 1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_q <= 2'd0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/plab4_net_router_output_terminal_ctrl.sv
// Terminal (ejection) output port ctrl: arbitrates the three inputs' reqs into a small
// ejection queue and drives valid/ready toward the terminal. Storage and xbar live in the datapath.
module plab4_net_router_output_terminal_ctrl
  import plab4_net_router_output_terminal_ctrl_pkg::*;
#(
  parameter  int p_router_id      = 0,
  parameter  int p_num_entries    = 4,
  parameter  int p_num_free_nbits = 3,
  localparam int c_addr_nbits     = $clog2(p_num_entries)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  reqs,
  output logic [2:0]                  grants,
  output logic [1:0]                  xbar_sel,
  output logic                        buf_wen,
  output logic [c_addr_nbits-1:0]     buf_waddr,
  output logic [c_addr_nbits-1:0]     buf_raddr,
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic [p_num_free_nbits-1:0] num_free
);

  localparam int c_cnt_nbits = c_addr_nbits + 1;

  logic [c_addr_nbits-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_addr_nbits-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_nbits-1:0]  count_q, count_d;
  logic                    full, arb_en, arb_valid, deq;
  logic [1:0]              winner;

  // Grant decision looks only at the registered count: a same-cycle dequeue never frees a slot early.
  assign full   = (count_q == c_cnt_nbits'(p_num_entries));
  assign arb_en = !full && !reset;

  plab4_net_RoundRobinArb3 u_arb (
    .clk    (clk),
    .reset  (reset),
    .reqs   (reqs),
    .en     (arb_en),
    .grants (grants),
    .winner (winner),
    .valid  (arb_valid)
  );

  assign buf_wen   = arb_valid;
  assign xbar_sel  = winner;
  assign buf_waddr = wr_ptr_q;
  assign buf_raddr = rd_ptr_q;
  assign out_val   = (count_q != '0);
  assign deq       = out_val && out_rdy;
  assign num_free  = p_num_free_nbits'(p_num_entries) - p_num_free_nbits'(count_q);

  always_comb begin
    wr_ptr_d = wr_ptr_q + c_addr_nbits'(buf_wen);
    rd_ptr_d = rd_ptr_q + c_addr_nbits'(deq);
    count_d  = count_q;
    case ({buf_wen, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (reset)
    count_q <= c_cnt_nbits'(p_num_entries))
    else $error("router %0d: ejection queue count overflow", p_router_id);
  a_grants_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grants));
  a_grants_subset: assert property (@(posedge clk) disable iff (reset) (grants & ~reqs) == 3'b000);
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(deq && count_q == '0));

endmodule

// File: tb/tb_plab4_net_router_output_terminal_ctrl.sv
// Directed bench for the terminal output ctrl: arbitration order, queue fill/drain,
// full blocking, simultaneous enq/deq, pointer wrap and asynchronous reset.
module tb_plab4_net_router_output_terminal_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] reqs;
  logic [2:0] grants;
  logic [1:0] xbar_sel;
  logic       buf_wen;
  logic [1:0] buf_waddr;
  logic [1:0] buf_raddr;
  logic       out_val;
  logic       out_rdy;
  logic [2:0] num_free;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] mem [4];
  logic [2:0] t6_reqs [6];
  logic [2:0] t6_grants [6];
  logic [1:0] t6_waddr [6];
  logic [1:0] t6_head [6];

  plab4_net_router_output_terminal_ctrl #(
    .p_router_id      (0),
    .p_num_entries    (4),
    .p_num_free_nbits (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reqs      (reqs),
    .grants    (grants),
    .xbar_sel  (xbar_sel),
    .buf_wen   (buf_wen),
    .buf_waddr (buf_waddr),
    .buf_raddr (buf_raddr),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .num_free  (num_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Move to the next cycle, drive inputs just after the edge, settle before checking.
  task automatic step(input logic [2:0] r, input logic rdy);
    @(posedge clk);
    #1;
    reqs    = r;
    out_rdy = rdy;
    #2;
  endtask

  initial begin
    // 1. reset held with all reqs and out_rdy high
    reset = 1'b1; reqs = 3'b111; out_rdy = 1'b1;
    #3;
    chk("t1_grants", 8'(grants), 8'd0);
    chk("t1_out_val", 8'(out_val), 8'd0);
    chk("t1_num_free", 8'(num_free), 8'd4);
    chk("t1_buf_wen", 8'(buf_wen), 8'd0);
    chk("t1_xbar_sel", 8'(xbar_sel), 8'd0);
    @(posedge clk); #3;
    chk("t1_grants_edge", 8'(grants), 8'd0);

    // 2. release reset, reqs=111 held: rotating grants, out_val from cycle 2
    @(posedge clk); #1; reset = 1'b0; #2;
    chk("t2_c1_grants", 8'(grants), 8'd1);
    chk("t2_c1_waddr", 8'(buf_waddr), 8'd0);
    chk("t2_c1_out_val", 8'(out_val), 8'd0);
    chk("t2_c1_buf_wen", 8'(buf_wen), 8'd1);
    step(3'b111, 1'b1);
    chk("t2_c2_grants", 8'(grants), 8'd2);
    chk("t2_c2_xbar_sel", 8'(xbar_sel), 8'd1);
    chk("t2_c2_out_val", 8'(out_val), 8'd1);
    chk("t2_c2_raddr", 8'(buf_raddr), 8'd0);
    chk("t2_c2_num_free", 8'(num_free), 8'd3);
    step(3'b111, 1'b1);
    chk("t2_c3_grants", 8'(grants), 8'd4);
    chk("t2_c3_xbar_sel", 8'(xbar_sel), 8'd2);
    chk("t2_c3_waddr", 8'(buf_waddr), 8'd2);
    step(3'b111, 1'b1);
    chk("t2_c4_grants", 8'(grants), 8'd1);
    chk("t2_c4_waddr", 8'(buf_waddr), 8'd3);
    chk("t2_c4_raddr", 8'(buf_raddr), 8'd2);
    step(3'b000, 1'b1);
    chk("t2_drain_grants", 8'(grants), 8'd0);
    chk("t2_drain_raddr", 8'(buf_raddr), 8'd3);

    // 3. reqs=010 with out_rdy low fills the queue, then no grant while full
    step(3'b010, 1'b0);
    chk("t3_c1_grants", 8'(grants), 8'd2);
    chk("t3_c1_waddr", 8'(buf_waddr), 8'd0);
    chk("t3_c1_num_free", 8'(num_free), 8'd4);
    chk("t3_c1_out_val", 8'(out_val), 8'd0);
    step(3'b010, 1'b0);
    chk("t3_c2_num_free", 8'(num_free), 8'd3);
    chk("t3_c2_grants", 8'(grants), 8'd2);
    step(3'b010, 1'b0);
    chk("t3_c3_num_free", 8'(num_free), 8'd2);
    step(3'b010, 1'b0);
    chk("t3_c4_num_free", 8'(num_free), 8'd1);
    chk("t3_c4_waddr", 8'(buf_waddr), 8'd3);
    step(3'b010, 1'b0);
    chk("t3_full_grants", 8'(grants), 8'd0);
    chk("t3_full_buf_wen", 8'(buf_wen), 8'd0);
    chk("t3_full_num_free", 8'(num_free), 8'd0);

    // 4. full with out_rdy high: dequeue first, grant only the following cycle
    step(3'b001, 1'b1);
    chk("t4_c1_grants", 8'(grants), 8'd0);
    chk("t4_c1_out_val", 8'(out_val), 8'd1);
    step(3'b001, 1'b1);
    chk("t4_c2_grants", 8'(grants), 8'd1);
    chk("t4_c2_waddr", 8'(buf_waddr), 8'd0);
    chk("t4_c2_num_free", 8'(num_free), 8'd1);

    // 5. queue at 2, enqueue and dequeue in the same cycle
    step(3'b000, 1'b1);
    chk("t5_pre_raddr", 8'(buf_raddr), 8'd2);
    step(3'b100, 1'b1);
    chk("t5_num_free", 8'(num_free), 8'd2);
    chk("t5_grants", 8'(grants), 8'd4);
    chk("t5_xbar_sel", 8'(xbar_sel), 8'd2);
    chk("t5_waddr", 8'(buf_waddr), 8'd1);
    chk("t5_raddr", 8'(buf_raddr), 8'd3);
    step(3'b000, 1'b0);
    chk("t5_post_num_free", 8'(num_free), 8'd2);
    chk("t5_post_waddr", 8'(buf_waddr), 8'd2);
    chk("t5_post_raddr", 8'(buf_raddr), 8'd0);

    // 6. six packets streamed through with out_rdy high: pointers wrap, heads in grant order
    step(3'b000, 1'b1);
    step(3'b000, 1'b1);
    chk("t6_drain_num_free", 8'(num_free), 8'd3);
    t6_reqs   = '{3'b110, 3'b011, 3'b101, 3'b111, 3'b100, 3'b010};
    t6_grants = '{3'b010, 3'b001, 3'b100, 3'b001, 3'b100, 3'b010};
    t6_waddr  = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    t6_head   = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1};
    for (int i = 0; i < 7; i++) begin
      step((i < 6) ? t6_reqs[i] : 3'b000, 1'b1);
      if (i < 6) begin
        chk($sformatf("t6_c%0d_grants", i), 8'(grants), 8'(t6_grants[i]));
        chk($sformatf("t6_c%0d_waddr", i), 8'(buf_waddr), 8'(t6_waddr[i]));
      end
      if (i == 0) chk("t6_c0_out_val", 8'(out_val), 8'd0);
      if (i > 0) begin
        chk($sformatf("t6_c%0d_out_val", i), 8'(out_val), 8'd1);
        chk($sformatf("t6_c%0d_head", i), 8'(mem[buf_raddr]), 8'(t6_head[i-1]));
      end
      if (buf_wen === 1'b1) mem[buf_waddr] = xbar_sel;
    end

    // 7. asynchronous reset with three packets queued
    step(3'b001, 1'b0);
    step(3'b001, 1'b0);
    step(3'b001, 1'b0);
    step(3'b111, 1'b0);
    chk("t7_pre_num_free", 8'(num_free), 8'd1);
    chk("t7_pre_out_val", 8'(out_val), 8'd1);
    #1; reset = 1'b1; #1;
    chk("t7_rst_out_val", 8'(out_val), 8'd0);
    chk("t7_rst_num_free", 8'(num_free), 8'd4);
    chk("t7_rst_grants", 8'(grants), 8'd0);
    @(posedge clk); #1; reset = 1'b0; #2;
    chk("t7_post_out_val", 8'(out_val), 8'd0);
    chk("t7_post_grants", 8'(grants), 8'd1);
    chk("t7_post_waddr", 8'(buf_waddr), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
